// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver that feeds a first-word-fall-through byte FIFO.
// The default frame is 8N1. Defining UART_RX_PARITY_EN changes the frame to 8E1 and adds parity_err_o.
// Ports:
//   wb_clk_i, wb_rst_i    : clock and synchronous active-high reset
//   rx_i                  : asynchronous serial input, idle high
//   clk_div_i             : clocks per bit; values below 4 act as 4; latched when a start edge is seen
//   rx_data_o, rx_valid_o : FIFO head byte and not-empty flag
//   rx_ready_i            : pops the head when rx_valid_o is also high
//   fifo_count_o          : FIFO occupancy, 0..FIFO_DEPTH
//   frame_err_o           : one-cycle pulse when the stop bit is sampled low
//   overrun_o             : one-cycle pulse when a good byte is dropped because the FIFO is full
//   parity_err_o          : (UART_RX_PARITY_EN only) one-cycle pulse when the even-parity check fails
//   busy_o                : receiver is not idle
module uart_rx_core #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        rx_i,
    input  logic [15:0]                 clk_div_i,
    output logic [7:0]                  rx_data_o,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        frame_err_o,
    output logic                        overrun_o,
`ifdef UART_RX_PARITY_EN
    output logic                        parity_err_o,
`endif
    output logic                        busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [15:0]            cnt_q, n_q, n_clamp;
    logic [2:0]             bit_idx_q;
    logic [7:0]             shift_q;
    logic                   frame_err_q, overrun_q;
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            fifo_count_q, fifo_count_d;
    logic                   rx_s, tick, full, pop, push, par_bad;

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign n_clamp = clk_div_i < 16'd4 ? 16'd4 : clk_div_i;
    assign tick    = state_q != IDLE && cnt_q == 16'd0;
    assign full    = fifo_count_q == (AW+1)'(FIFO_DEPTH);
    assign pop     = rx_valid_o && rx_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the byte.
    assign push    = state_q == STOP && tick && rx_s && !par_bad && (!full || pop);
    assign fifo_count_d = fifo_count_q + (AW+1)'(push) - (AW+1)'(pop);

    assign rx_valid_o   = fifo_count_q != '0;
    assign rx_data_o    = rx_valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count_o = fifo_count_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = state_q != IDLE;

`ifdef UART_RX_PARITY_EN
    logic par_q, parity_err_q;
    assign par_bad      = ^shift_q ^ par_q;
    assign parity_err_o = parity_err_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) sync_q <= '1;
        else sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            n_q         <= 16'd4;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (state_q != IDLE && cnt_q != 16'd0) cnt_q <= cnt_q - 16'd1;
            case (state_q)
                IDLE: if (!rx_s) begin
                    n_q     <= n_clamp;
                    cnt_q   <= (n_clamp >> 1) - 16'd1;
                    state_q <= START;
                end
                START: if (tick) begin
                    cnt_q     <= n_q - 16'd1;
                    bit_idx_q <= 3'd0;
                    state_q   <= rx_s ? IDLE : DATA;
                end
                DATA: if (tick) begin
                    shift_q   <= {rx_s, shift_q[7:1]};
                    cnt_q     <= n_q - 16'd1;
                    bit_idx_q <= bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    state_q   <= bit_idx_q == 3'd7 ? PARITY : DATA;
`else
                    state_q   <= bit_idx_q == 3'd7 ? STOP : DATA;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick) begin
                    par_q   <= rx_s;
                    cnt_q   <= n_q - 16'd1;
                    state_q <= STOP;
                end
`endif
                // Return to IDLE at mid-stop so a back-to-back start edge is not missed.
                STOP: if (tick) begin
                    frame_err_q <= !rx_s;
                    overrun_q   <= rx_s && !par_bad && full && !pop;
`ifdef UART_RX_PARITY_EN
                    parity_err_q <= rx_s && par_bad;
`endif
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            fifo_count_q <= fifo_count_d;
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized self-checking bench for uart_rx_core against a queue-based frame model.
module tb_uart_rx_core;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, rdy = 1'b0;
    logic [15:0] div = 16'd16;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, frame_err_o, overrun_o, busy_o;
    logic [2:0]  fifo_count_o;
`ifdef UART_RX_PARITY_EN
    logic        parity_err_o;
`endif
    int pass_cnt = 0, total_cnt = 0;
    int fe_seen = 0, ov_seen = 0, pe_seen = 0;
    int probe_at = -1;
    logic probe_v0 = 1'b0, probe_v1 = 1'b0;
    logic [7:0] model_q [$];

    uart_rx_core #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .rx_i(rx), .clk_div_i(div),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rdy),
        .fifo_count_o(fifo_count_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err_o),
`endif
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err_o) fe_seen++;
        if (overrun_o) ov_seen++;
`ifdef UART_RX_PARITY_EN
        if (parity_err_o) pe_seen++;
`endif
    end

    function automatic int eff_n(input int d);
        return d < 4 ? 4 : d;
    endfunction

    // Cycle index (from the start-bit edge) on which the receiver evaluates the stop bit:
    // two synchronizer cycles, half a bit to the start-bit centre, then one bit per remaining field.
    function automatic int stop_cycle(input int d);
        return 2 + eff_n(d) / 2 + eff_n(d) * (NB - 1);
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_ok,
                              input int d, input int gap_bits, input int pop_at);
        int n;
        logic bits [12];
        n = eff_n(d);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^b) ^ !par_ok;
        bits[10] = stop_bit;
`else
        bits[9]  = stop_bit;
`endif
        div = 16'(d);
        for (int c = 0; c < (NB + gap_bits) * n; c++) begin
            @(negedge clk);
            if (c == probe_at) probe_v0 = rx_valid_o;
            if (c == probe_at + 1) probe_v1 = rx_valid_o;
            rx  = c < NB * n ? bits[c/n] : 1'b1;
            rdy = c == pop_at;
        end
    endtask

    task automatic drain(input string tag);
        while (model_q.size() != 0) begin
            @(negedge clk);
            total_cnt++;
            if (rx_valid_o !== 1'b1 || rx_data_o !== model_q[0])
                $display("FAIL %s pop: valid=%b data=%h, expected valid=1 data=%h", tag, rx_valid_o, rx_data_o, model_q[0]);
            else pass_cnt++;
            rdy = 1'b1;
            void'(model_q.pop_front());
        end
        @(negedge clk);
        rdy = 1'b0;
        total_cnt++;
        if (rx_valid_o !== 1'b0 || fifo_count_o !== 3'd0)
            $display("FAIL %s empty: valid=%b count=%0d, expected 0/0", tag, rx_valid_o, fifo_count_o);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({rx_data_o, rx_valid_o, fifo_count_o, frame_err_o, overrun_o, busy_o} !== 15'd0)
            $display("FAIL reset_outputs: data=%h valid=%b count=%0d fe=%b ov=%b busy=%b, expected all 0",
                     rx_data_o, rx_valid_o, fifo_count_o, frame_err_o, overrun_o, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_single();
        probe_at = stop_cycle(16);
        send_frame(8'h3D, 1'b1, 1'b1, 16, 0, -1);
        probe_at = -1;
        model_q.push_back(8'h3D);
        total_cnt++;
        if (probe_v0 !== 1'b0 || probe_v1 !== 1'b1)
            $display("FAIL push_latency: valid before/after stop tick=%b/%b, expected 0/1", probe_v0, probe_v1);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (rx_data_o !== 8'h3D || rx_valid_o !== 1'b1 || fifo_count_o !== 3'd1)
            $display("FAIL single: data=%h valid=%b count=%0d, expected 3d/1/1", rx_data_o, rx_valid_o, fifo_count_o);
        else pass_cnt++;
        drain("single");
        rdy = 1'b1;
        repeat (3) @(negedge clk);
        rdy = 1'b0;
        total_cnt++;
        if (fifo_count_o !== 3'd0 || rx_valid_o !== 1'b0)
            $display("FAIL pop_empty: count=%0d valid=%b, expected 0/0", fifo_count_o, rx_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4] = '{8'h0F, 8'hAB, 8'h55, 8'h00};
        int fe0 = fe_seen, ov0 = ov_seen;
        for (int i = 0; i < 4; i++) begin
            send_frame(seq[i], 1'b1, 1'b1, 16, 0, -1);
            model_q.push_back(seq[i]);
        end
        repeat (4) @(negedge clk);
        total_cnt++;
        if (fifo_count_o !== 3'd4 || fe_seen != fe0 || ov_seen != ov0)
            $display("FAIL back_to_back: count=%0d fe=%0d ov=%0d, expected 4/0/0", fifo_count_o, fe_seen - fe0, ov_seen - ov0);
        else pass_cnt++;
        rx = 1'b1;
        drain("back_to_back");
    endtask

    task automatic test_overrun();
        logic [7:0] seq [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int ov0 = ov_seen;
        for (int i = 0; i < 4; i++) begin
            send_frame(seq[i], 1'b1, 1'b1, 16, 0, -1);
            model_q.push_back(seq[i]);
        end
        send_frame(8'h77, 1'b1, 1'b1, 16, 1, -1);
        total_cnt++;
        if (ov_seen - ov0 != 1 || fifo_count_o !== 3'd4 || rx_data_o !== 8'h11)
            $display("FAIL overrun: pulses=%0d count=%0d head=%h, expected 1/4/11", ov_seen - ov0, fifo_count_o, rx_data_o);
        else pass_cnt++;
        ov0 = ov_seen;
        send_frame(8'h99, 1'b1, 1'b1, 16, 1, stop_cycle(16));
        void'(model_q.pop_front());
        model_q.push_back(8'h99);
        total_cnt++;
        if (ov_seen != ov0 || fifo_count_o !== 3'd4 || rx_data_o !== 8'h22)
            $display("FAIL full_push_pop: pulses=%0d count=%0d head=%h, expected 0/4/22", ov_seen - ov0, fifo_count_o, rx_data_o);
        else pass_cnt++;
        drain("overrun");
    endtask

    task automatic test_frame_err();
        int fe0 = fe_seen, ov0 = ov_seen;
        send_frame(8'hA5, 1'b0, 1'b1, 16, 2, -1);
        total_cnt++;
        if (fe_seen - fe0 != 1 || fifo_count_o !== 3'd0 || busy_o !== 1'b0)
            $display("FAIL frame_err: pulses=%0d count=%0d busy=%b, expected 1/0/0", fe_seen - fe0, fifo_count_o, busy_o);
        else pass_cnt++;
        fe0 = fe_seen;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            rx = c >= 6;
        end
        total_cnt++;
        if (fe_seen != fe0 || ov_seen != ov0 || fifo_count_o !== 3'd0 || busy_o !== 1'b0)
            $display("FAIL glitch: fe=%0d ov=%0d count=%0d busy=%b, expected 0/0/0/0", fe_seen - fe0, ov_seen - ov0, fifo_count_o, busy_o);
        else pass_cnt++;
        // Held-low line: one error per re-synchronised frame, released while the fourth start check is pending.
        for (int c = 0; c < 463 + 48; c++) begin
            @(negedge clk);
            rx = c >= 463;
        end
        total_cnt++;
        if (fe_seen - fe0 != 3 || fifo_count_o !== 3'd0 || busy_o !== 1'b0)
            $display("FAIL break: pulses=%0d count=%0d busy=%b, expected 3/0/0", fe_seen - fe0, fifo_count_o, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        logic [7:0] b = 8'hC3;
        int fe0, ov0;
        send_frame(8'hAA, 1'b1, 1'b1, 16, 0, -1);
        send_frame(8'h55, 1'b1, 1'b1, 16, 0, -1);
        fe0 = fe_seen;
        ov0 = ov_seen;
        for (int c = 0; c < 88; c++) begin
            @(negedge clk);
            rx = c < 16 ? 1'b0 : b[c/16-1];
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        model_q.delete();
        total_cnt++;
        if (fifo_count_o !== 3'd0 || rx_valid_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL mid_reset: count=%0d valid=%b busy=%b, expected 0/0/0", fifo_count_o, rx_valid_o, busy_o);
        else pass_cnt++;
        repeat (48) @(negedge clk);
        send_frame(8'h3D, 1'b1, 1'b1, 16, 1, -1);
        model_q.push_back(8'h3D);
        total_cnt++;
        if (fifo_count_o !== 3'd1 || rx_data_o !== 8'h3D || fe_seen != fe0 || ov_seen != ov0)
            $display("FAIL after_reset: count=%0d data=%h fe=%0d ov=%0d, expected 1/3d/0/0",
                     fifo_count_o, rx_data_o, fe_seen - fe0, ov_seen - ov0);
        else pass_cnt++;
        drain("after_reset");
    endtask

    task automatic test_random();
        int fe0 = fe_seen, ov0 = ov_seen, fe_exp = 0, ov_exp = 0;
        for (int i = 0; i < 40; i++) begin
            int d, gap;
            logic [7:0] b;
            logic bad;
            d   = i == 0 ? 1 : int'($urandom_range(0, 24));
            b   = 8'($urandom);
            bad = $urandom_range(0, 4) == 0;
            gap = bad ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            send_frame(b, !bad, 1'b1, d, gap, -1);
            if (bad) fe_exp++;
            else if (model_q.size() == FIFO_DEPTH) ov_exp++;
            else model_q.push_back(b);
            if ($urandom_range(0, 2) == 0) drain("random");
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        total_cnt++;
        if (fe_seen - fe0 != fe_exp || ov_seen - ov0 != ov_exp || fifo_count_o !== 3'(model_q.size()))
            $display("FAIL random_counts: fe=%0d ov=%0d count=%0d, expected %0d/%0d/%0d",
                     fe_seen - fe0, ov_seen - ov0, fifo_count_o, fe_exp, ov_exp, model_q.size());
        else pass_cnt++;
        drain("random");
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int fe0 = fe_seen, pe0 = pe_seen;
        send_frame(8'h3D, 1'b1, 1'b1, 16, 1, -1);
        model_q.push_back(8'h3D);
        total_cnt++;
        if (fifo_count_o !== 3'd1 || pe_seen != pe0)
            $display("FAIL parity_good: count=%0d pe=%0d, expected 1/0", fifo_count_o, pe_seen - pe0);
        else pass_cnt++;
        send_frame(8'h3D, 1'b1, 1'b0, 16, 1, -1);
        total_cnt++;
        if (fifo_count_o !== 3'd1 || pe_seen - pe0 != 1 || fe_seen != fe0)
            $display("FAIL parity_bad: count=%0d pe=%0d fe=%0d, expected 1/1/0", fifo_count_o, pe_seen - pe0, fe_seen - fe0);
        else pass_cnt++;
        pe0 = pe_seen;
        send_frame(8'h3D, 1'b0, 1'b0, 16, 1, -1);
        total_cnt++;
        if (fifo_count_o !== 3'd1 || pe_seen != pe0 || fe_seen - fe0 != 1)
            $display("FAIL parity_and_stop: count=%0d pe=%0d fe=%0d, expected 1/0/1", fifo_count_o, pe_seen - pe0, fe_seen - fe0);
        else pass_cnt++;
        drain("parity");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_mid_reset();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
